// File: rtl/conv1x1_ofm_writer.sv
// OFM write side of the 1x1 conv engine: captures 4-lane PE results into a 2-slot ping-pong
// buffer and drains them one word per cycle. Define OFM_RELU_EN to zero negative output words.
module conv1x1_ofm_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cal_start,
  input  logic [10:0]         num_filter,
  input  logic [3:0]          PE_finish,
  input  logic [4*DATA_W-1:0] pe_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   addr_ofm,
  output logic [DATA_W-1:0]   data_ofm,
  output logic                pixel_done,
  output logic                overflow,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, WRITE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [1:0]          valid_q, valid_d;
  logic [4*DATA_W-1:0] slot_data_q [2];
  logic [4*DATA_W-1:0] slot_data_d [2];
  logic [10:0]         tag_fb_q [2];
  logic [10:0]         tag_fb_d [2];
  logic [ADDR_W-1:0]   tag_pb_q [2];
  logic [ADDR_W-1:0]   tag_pb_d [2];
  logic                wp_q, wp_d, rp_q, rp_d;
  logic [1:0]          lane_q, lane_d;
  logic [10:0]         fb_q, fb_d;
  logic [ADDR_W-1:0]   pb_q, pb_d;
  logic                prev_all_q, prev_all_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                pixel_done_q, pixel_done_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;

  logic                all_ones_s, cap_s, last_s, release_s, slot_free_s;
  logic [11:0]         fb_next_s, lane_end_s, grp_end_s;
  logic [DATA_W-1:0]   word_s;

  // Next-state logic: drain FSM, slot bookkeeping, capture and group counters.
  always_comb begin
    all_ones_s  = (PE_finish == 4'b1111);
    cap_s       = all_ones_s && !prev_all_q && (state_q != IDLE) && cal_start;
    word_s      = slot_data_q[rp_q][int'(lane_q)*DATA_W +: DATA_W];
    lane_end_s  = {1'b0, tag_fb_q[rp_q]} + {10'd0, lane_q} + 12'd1;
    grp_end_s   = {1'b0, tag_fb_q[rp_q]} + 12'd4;
    // Lanes past num_filter are never issued, so the slot ends on the last in-range lane.
    last_s      = (lane_q == 2'd3) || (lane_end_s >= {1'b0, num_filter});
    release_s   = (state_q == WRITE) && cal_start && last_s;
    slot_free_s = !valid_q[wp_q] || (release_s && (rp_q == wp_q));
    fb_next_s   = {1'b0, fb_q} + 12'd4;

    state_d      = state_q;
    valid_d      = valid_q;
    slot_data_d  = slot_data_q;
    tag_fb_d     = tag_fb_q;
    tag_pb_d     = tag_pb_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    lane_d       = lane_q;
    fb_d         = fb_q;
    pb_d         = pb_q;
    prev_all_d   = all_ones_s;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    pixel_done_d = 1'b0;
    overflow_d   = overflow_q;
    busy_d       = |valid_q;

    case (state_q)
      IDLE: begin
        if (cal_start) begin
          state_d    = ARMED;
          fb_d       = 11'd0;
          pb_d       = {ADDR_W{1'b0}};
          prev_all_d = 1'b0;
          overflow_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (valid_q[rp_q]) begin
          state_d = WRITE;
          lane_d  = 2'd0;
        end else begin
          state_d = ARMED;
        end
      end
      WRITE: begin
        wr_en_d      = 1'b1;
        addr_d       = tag_pb_q[rp_q] + ADDR_W'(tag_fb_q[rp_q]) + ADDR_W'(lane_q);
`ifdef OFM_RELU_EN
        data_d       = word_s[DATA_W-1] ? {DATA_W{1'b0}} : word_s;
`else
        data_d       = word_s;
`endif
        pixel_done_d = last_s && (grp_end_s >= {1'b0, num_filter});
        if (last_s) begin
          valid_d[rp_q] = 1'b0;
          rp_d          = ~rp_q;
          lane_d        = 2'd0;
          state_d       = valid_q[~rp_q] ? WRITE : ARMED;
        end else begin
          lane_d = lane_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture after release so a slot freed this cycle can be refilled in the same edge.
    if (cap_s) begin
      if (num_filter == 11'd0) begin
        overflow_d = 1'b1;
      end else if (slot_free_s) begin
        valid_d[wp_q]     = 1'b1;
        slot_data_d[wp_q] = pe_data;
        tag_fb_d[wp_q]    = fb_q;
        tag_pb_d[wp_q]    = pb_q;
        wp_d              = ~wp_q;
        if (fb_next_s >= {1'b0, num_filter}) begin
          fb_d = 11'd0;
          pb_d = pb_q + ADDR_W'(num_filter);
        end else begin
          fb_d = fb_next_s[10:0];
        end
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      overflow_d = overflow_d;
    end

    if (!cal_start) begin
      state_d      = IDLE;
      valid_d      = 2'b00;
      lane_d       = 2'd0;
      wp_d         = 1'b0;
      rp_d         = 1'b0;
      wr_en_d      = 1'b0;
      pixel_done_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= 2'b00;
      slot_data_q  <= '{default: '0};
      tag_fb_q     <= '{default: '0};
      tag_pb_q     <= '{default: '0};
      wp_q         <= 1'b0;
      rp_q         <= 1'b0;
      lane_q       <= 2'd0;
      fb_q         <= 11'd0;
      pb_q         <= {ADDR_W{1'b0}};
      prev_all_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      pixel_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      slot_data_q  <= slot_data_d;
      tag_fb_q     <= tag_fb_d;
      tag_pb_q     <= tag_pb_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      lane_q       <= lane_d;
      fb_q         <= fb_d;
      pb_q         <= pb_d;
      prev_all_q   <= prev_all_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      pixel_done_q <= pixel_done_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign addr_ofm   = addr_q;
  assign data_ofm   = data_q;
  assign pixel_done = pixel_done_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule
